// File: rtl/ghostchip_scanout.sv
// Video scan-out for ghostchip: maps raster position to frame-buffer address with per-mode
// integer scaling and centring, then palettes the returned pixel behind a latency-matched delay.
module ghostchip_scanout #(
  parameter int unsigned H_ACTIVE = 256,
  parameter int unsigned V_ACTIVE = 240,
  parameter int unsigned SCALE_LO = 4,
  parameter int unsigned SCALE_HI = 2,
  parameter int unsigned RGB_W    = 3,
  parameter int unsigned VRAM_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hires,
  input  logic [8:0]       hpos,
  input  logic [8:0]       vpos,
  input  logic             display_on,
  input  logic             hsync_in,
  input  logic             vsync_in,
  output logic [6:0]       vram_hpos,
  output logic [5:0]       vram_vpos,
  input  logic [1:0]       vram_pixel,
  input  logic             pal_we,
  input  logic [2:0]       pal_idx,
  input  logic [RGB_W-1:0] pal_data,
  output logic [RGB_W-1:0] rgb,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_start
);

  localparam int unsigned XOFF_LO = (H_ACTIVE - 64 * SCALE_LO) / 2;
  localparam int unsigned XOFF_HI = (H_ACTIVE - 128 * SCALE_HI) / 2;
  localparam int unsigned YOFF_LO = (V_ACTIVE - 32 * SCALE_LO) / 2;
  localparam int unsigned YOFF_HI = (V_ACTIVE - 64 * SCALE_HI) / 2;

  logic       mode_q;
  logic       origin;
  logic       mode_cur;
  logic [9:0] hpos_w, vpos_w;
  logic [9:0] x_off, x_end, y_off, y_end;
  logic [7:0] s_m1;
  logic [6:0] w_m1;
  logic [5:0] h_m1;
  logic       in_box;

  logic [7:0] sx_q, sx_d, sy_q, sy_d;
  logic [6:0] col_q, col_d;
  logic [5:0] row_q, row_d;

  // Qualifier bundle: {in_box, display_on, hsync, vsync}
  logic [3:0] s0_q;
  logic [3:0] dly_q [VRAM_LAT];
  logic [3:0] tail;

  logic [RGB_W-1:0] pal_q [5];
  logic [RGB_W-1:0] rgb_d;

  assign origin = (hpos == 9'd0) && (vpos == 9'd0);
  // The origin cycle already belongs to the new frame, so it uses the incoming mode.
  assign mode_cur = origin ? hires : mode_q;
  assign hpos_w = {1'b0, hpos};
  assign vpos_w = {1'b0, vpos};

  always_comb begin
    x_off = 10'(XOFF_LO);
    x_end = 10'(XOFF_LO + 64 * SCALE_LO);
    y_off = 10'(YOFF_LO);
    y_end = 10'(YOFF_LO + 32 * SCALE_LO);
    s_m1  = 8'(SCALE_LO - 1);
    w_m1  = 7'd63;
    h_m1  = 6'd31;
    if (mode_cur) begin
      x_off = 10'(XOFF_HI);
      x_end = 10'(XOFF_HI + 128 * SCALE_HI);
      y_off = 10'(YOFF_HI);
      y_end = 10'(YOFF_HI + 64 * SCALE_HI);
      s_m1  = 8'(SCALE_HI - 1);
      w_m1  = 7'd127;
      h_m1  = 6'd63;
    end
  end

  assign in_box = (hpos_w >= x_off) && (hpos_w < x_end) && (vpos_w >= y_off) && (vpos_w < y_end);

  always_comb begin
    sx_d  = sx_q;
    col_d = col_q;
    sy_d  = sy_q;
    row_d = row_q;
    if (hpos_w == x_off) begin
      sx_d  = '0;
      col_d = '0;
    end else if (sx_q >= s_m1) begin
      sx_d  = '0;
      col_d = (col_q < w_m1) ? col_q + 7'd1 : w_m1;
    end else begin
      sx_d = sx_q + 8'd1;
    end
    if (hpos == 9'd0) begin
      if (vpos_w == y_off) begin
        sy_d  = '0;
        row_d = '0;
      end else if (sy_q >= s_m1) begin
        sy_d  = '0;
        row_d = (row_q < h_m1) ? row_q + 6'd1 : h_m1;
      end else begin
        sy_d = sy_q + 8'd1;
      end
    end
    // Saturate rather than wrap; also pulls stale hires addresses into lores range.
    if (col_d > w_m1) col_d = w_m1;
    if (row_d > h_m1) row_d = h_m1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q      <= 1'b0;
      frame_start <= 1'b0;
      sx_q        <= '0;
      col_q       <= '0;
      sy_q        <= '0;
      row_q       <= '0;
      s0_q        <= '0;
    end else begin
      if (origin) mode_q <= hires;
      frame_start <= origin;
      sx_q        <= sx_d;
      col_q       <= col_d;
      sy_q        <= sy_d;
      row_q       <= row_d;
      s0_q        <= {in_box, display_on, hsync_in, vsync_in};
    end
  end

  assign vram_hpos = col_q;
  assign vram_vpos = row_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < VRAM_LAT; i++) dly_q[i] <= '0;
    end else begin
      dly_q[0] <= s0_q;
      for (int unsigned i = 1; i < VRAM_LAT; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign tail = dly_q[VRAM_LAT-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 5; i++) pal_q[i] <= (i < 4) ? RGB_W'(i) : '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (pal_we && (pal_idx == 3'(i))) pal_q[i] <= pal_data;
      end
    end
  end

  always_comb begin
    rgb_d = '0;
    if (tail[2]) begin
      rgb_d = tail[3] ? pal_q[{1'b0, vram_pixel}] : pal_q[3'd4];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb   <= '0;
      hsync <= 1'b0;
      vsync <= 1'b0;
    end else begin
      rgb   <= rgb_d;
      hsync <= tail[1];
      vsync <= tail[0];
    end
  end

endmodule

// File: tb/tb_ghostchip_scanout.sv
// Bench for ghostchip_scanout: two instances (VRAM latency 1 and 3) share randomised raster
// stimulus and are compared against a division-based model of scaling, box and palette.
module tb_ghostchip_scanout;

  localparam int HA = 256;
  localparam int VA = 240;

  logic       clk = 1'b0;
  logic       reset;
  logic       hires;
  logic [8:0] hpos, vpos;
  logic       display_on, hsync_in, vsync_in;
  logic       pal_we;
  logic [2:0] pal_idx, pal_data;

  logic [6:0] vh1, vh3;
  logic [5:0] vv1, vv3;
  logic [1:0] px1, px3;
  logic [2:0] rgb1, rgb3;
  logic       hs1, hs3, vs1, vs3, fs1, fs3;

  always #5 clk = ~clk;

  ghostchip_scanout #(.VRAM_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .hires(hires), .hpos(hpos), .vpos(vpos),
    .display_on(display_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .vram_hpos(vh1), .vram_vpos(vv1), .vram_pixel(px1),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
    .rgb(rgb1), .hsync(hs1), .vsync(vs1), .frame_start(fs1)
  );

  ghostchip_scanout #(.VRAM_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .hires(hires), .hpos(hpos), .vpos(vpos),
    .display_on(display_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .vram_hpos(vh3), .vram_vpos(vv3), .vram_pixel(px3),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
    .rgb(rgb3), .hsync(hs3), .vsync(vs3), .frame_start(fs3)
  );

  // Frame buffer contents and VRAM read pipelines, indexed row*128+col.
  logic [1:0] mem [8192];
  logic [1:0] pipe1;
  logic [1:0] pipe3 [3];

  always @(posedge clk) begin
    pipe1    <= mem[{vv1, vh1}];
    pipe3[0] <= mem[{vv3, vh3}];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  assign px1 = pipe1;
  assign px3 = pipe3[2];

  // Reference model state
  int         n_cmp = 0;
  int         n_fail = 0;
  int         n = 0;
  logic       mode_m;
  bit         hsy, vsy;
  logic [2:0] pal_m [5];
  bit         h_val [8];
  bit         h_don [8];
  bit         h_box [8];
  bit         h_chk [8];
  bit         h_hs  [8];
  bit         h_vs  [8];
  logic [1:0] h_pix [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_rgb(input int sl);
    if (!h_val[sl] || !h_don[sl]) return 3'd0;
    if (h_box[sl]) return pal_m[h_pix[sl]];
    return pal_m[4];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) h_val[i] = 1'b0;
    mode_m = 1'b0;
    hsy = 1'b0;
    vsy = 1'b0;
    for (int i = 0; i < 5; i++) pal_m[i] = (i < 4) ? 3'(i) : 3'd0;
  endtask

  task automatic do_reset(input int hold);
    reset  = 1'b0;
    pal_we = 1'b0;
    #1;
    chk("async_reset_lat1", {13'd0, rgb1, hs1, vs1, fs1, vh1, vv1}, 32'd0);
    chk("async_reset_lat3", {13'd0, rgb3, hs3, vs3, fs3, vh3, vv3}, 32'd0);
    repeat (hold) @(posedge clk);
    #2;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic cyc(input int h, input int v);
    int         s, w, hh, xo, yo, col, row, sl, sl1, sl3;
    bit         box, org, c1, c3;
    logic [2:0] e1, e3;
    logic [1:0] sy1, sy3;
    hpos       = 9'(h);
    vpos       = 9'(v);
    display_on = (h < HA + 4) && (v < VA) && ($urandom_range(15) != 0);
    hsync_in   = 1'($urandom);
    vsync_in   = 1'($urandom);
    pal_we     = ($urandom_range(23) == 0);
    pal_idx    = 3'($urandom);
    pal_data   = 3'($urandom);
    @(posedge clk);
    org = (h == 0) && (v == 0);
    if (org) mode_m = hires;
    s  = mode_m ? 2 : 4;
    w  = mode_m ? 128 : 64;
    hh = mode_m ? 64 : 32;
    xo = (HA - w * s) / 2;
    yo = (VA - hh * s) / 2;
    box = (h >= xo) && (h < xo + w * s) && (v >= yo) && (v < yo + hh * s);
    if (h == xo) hsy = 1'b1;
    if (h == 0 && v == yo) vsy = 1'b1;
    col = box ? (h - xo) / s : 0;
    row = box ? (v - yo) / s : 0;
    sl = n & 7;
    h_val[sl] = 1'b1;
    h_don[sl] = display_on;
    h_box[sl] = box;
    h_chk[sl] = !box || (hsy && vsy);
    h_hs[sl]  = hsync_in;
    h_vs[sl]  = vsync_in;
    h_pix[sl] = box ? mem[row * 128 + col] : 2'd0;
    sl1 = (n - 2) & 7;
    sl3 = (n - 4) & 7;
    e1  = exp_rgb(sl1);
    e3  = exp_rgb(sl3);
    c1  = !h_val[sl1] || h_chk[sl1];
    c3  = !h_val[sl3] || h_chk[sl3];
    sy1 = h_val[sl1] ? {h_hs[sl1], h_vs[sl1]} : 2'b00;
    sy3 = h_val[sl3] ? {h_hs[sl3], h_vs[sl3]} : 2'b00;
    // A write at this edge is not visible to the colour registered at the same edge.
    if (pal_we && pal_idx < 3'd5) pal_m[pal_idx] = pal_data;
    n++;
    #1;
    if (c1) chk("rgb_lat1", {29'd0, rgb1}, {29'd0, e1});
    if (c3) chk("rgb_lat3", {29'd0, rgb3}, {29'd0, e3});
    chk("sync_lat1", {30'd0, hs1, vs1}, {30'd0, sy1});
    chk("sync_lat3", {30'd0, hs3, vs3}, {30'd0, sy3});
    chk("frame_start", {30'd0, fs1, fs3}, {30'd0, org, org});
    if (box && hsy) chk("vram_hpos", {18'd0, vh1, vh3}, {18'd0, 7'(col), 7'(col)});
    if (box && vsy) chk("vram_vpos", {20'd0, vv1, vv3}, {20'd0, 6'(row), 6'(row)});
    if (!mode_m) chk("lores_addr_msbs", {28'd0, vh1[6], vv1[5], vh3[6], vv3[5]}, 32'd0);
  endtask

  task automatic line(input int v, input int first, input int last);
    for (int h = first; h <= last; h++) cyc(h, v);
  endtask

  function automatic int line_end(input int v);
    if (v == 0 || v == 55 || v == 56 || v == 57 || v == 60 || v == 120 ||
        v == 183 || v == 184 || v == 239 || v == 240 || $urandom_range(29) == 0) return 259;
    return int'($urandom_range(14, 4));
  endfunction

  task automatic frame(input int k);
    for (int v = 0; v < 262; v++) begin
      if (k == 0 && v == 100) hires = 1'b1;
      if (k == 2) hires = (v == 0) ? 1'b1 : 1'($urandom);
      if (k == 3) hires = 1'($urandom);
      if (k == 1 && v == 80) begin
        line(v, 0, 99);
        do_reset(2);
        line(v, 100, 259);
      end else begin
        line(v, 0, line_end(v));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 2'($urandom);
    reset      = 1'b1;
    hires      = 1'b0;
    hpos       = '0;
    vpos       = '0;
    display_on = 1'b0;
    hsync_in   = 1'b0;
    vsync_in   = 1'b0;
    pal_we     = 1'b0;
    pal_idx    = '0;
    pal_data   = '0;
    model_reset();
    #2;
    do_reset(3);
    frame(0);
    frame(1);
    frame(2);
    frame(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ghostchip_scanout.md
# ghostchip_scanout

Parametrised video scan-out engine for the ghostchip console, replacing the fixed lores/hires pixel mapper between the CHIP-8 frame buffer and the hvsync generator. It converts raster position into frame-buffer coordinates with per-mode integer scaling and centring. It pipelines around the VRAM read latency and maps 2-bit pixels through a writable palette with a border colour. Mode changes are applied only at frame boundaries, so a hires toggle mid-frame never tears the picture.

## Interface
Parameters:
- H_ACTIVE, 256: visible pixels per line.
- V_ACTIVE, 240: visible lines per frame.
- SCALE_LO, 4: integer scale in lores mode (64x32 image).
- SCALE_HI, 2: integer scale in hires mode (128x64 image).
- RGB_W, 3: output colour width.
- VRAM_LAT, 1: VRAM read latency in cycles, 1..3.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  asynchronous, active-low reset.
- hires  in  1  requested mode from the CPU.
- hpos  in  9  raster x from hvsync generator.
- vpos  in  9  raster y from hvsync generator.
- display_on  in  1  visible-area flag.
- hsync_in  in  1  raw hsync.
- vsync_in  in  1  raw vsync.
- vram_hpos  out  7  frame-buffer column.
- vram_vpos  out  6  frame-buffer row.
- vram_pixel  in  2  pixel data, valid VRAM_LAT cycles after the address.
- pal_we  in  1  palette write strobe.
- pal_idx  in  3  entry: 0..3 pixel colours, 4 border; 5..7 ignored.
- pal_data  in  RGB_W  colour to write.
- rgb  out  RGB_W  colour output.
- hsync  out  1  delayed hsync aligned to rgb.
- vsync  out  1  delayed vsync aligned to rgb.
- frame_start  out  1  one-cycle pulse when the mode latch updates.

## Operation
- Mode latch mode_q: loads `hires` on the cycle where hpos==0 and vpos==0, and pulses frame_start on that cycle. The current mode_q is used for the whole frame.
- Derived per mode:
  - W=64/128, H=32/64, S=SCALE_LO/SCALE_HI.
  - x_off=(H_ACTIVE-W*S)/2, y_off=(V_ACTIVE-H*S)/2, computed with truncating division.
  - Parameter combinations with W*S>H_ACTIVE or H*S>V_ACTIVE are illegal.
- Scaling uses counters; no dividers are allowed.
  - Horizontal: sx (0..S-1) and col. Both clear when hpos==x_off. sx wraps at S-1 and col increments on each wrap.
  - Vertical: sy and row. Both clear at hpos==0 with vpos==y_off. They advance at hpos==0 of each following line in the same wrap manner.
- in_box = hpos in [x_off, x_off+W*S) and vpos in [y_off, y_off+H*S).
- vram_hpos = col; vram_vpos = row. Both are registered. In lores, bit 6 of vram_hpos and bit 5 of vram_vpos are 0.
- Colour select at the output stage:
  - display_on low: rgb=0.
  - in_box: pal[vram_pixel].
  - otherwise: pal[4] (border).
- Palette reset values: pal0=0, pal1=1, pal2=2, pal3=3, pal4 (border)=0. For RGB_W=3 this gives {0,p1,p0}.
- A palette write lands at the clock edge. A same-cycle read of the same entry returns the old value.
- Writes to pal_idx 5..7 have no effect.

## Timing
- Reset (asynchronous, active-low):
  - rgb=0, hsync=0, vsync=0, frame_start=0, vram_hpos=0, vram_vpos=0.
  - mode_q=0 (lores); all counters 0; palette returns to its reset values.
  - All delay-line stages clear to 0.
- Latency D=VRAM_LAT+2 cycles, identical for rgb, hsync, vsync and the in_box/display_on qualifiers.
  - The address register is 1 stage, followed by VRAM_LAT stages, followed by 1 output register.
  - Inputs sampled at edge k appear on outputs after edge k+D-1.
- frame_start is not delayed: it is asserted the cycle after hpos=vpos=0 is sampled.
- Scanning past the last column or row does not wrap the address; in_box is low there and the border colour is shown.
- Reset asserted mid-frame: outputs clear immediately. After release, the block is in lores mode until the next frame origin, with counters resynchronised at the next x_off/y_off match.
- A hires change mid-frame has no effect until the next hpos=vpos=0.

## Test plan
- Reset, default parameters, lores, a VRAM model with VRAM_LAT=1 returning pixel=col[1:0] -> first box pixel at hpos=0, vpos=56. Rgb shows 0 for 4 pixels, then 1 for 4 pixels, and so on. rgb changes exactly 3 cycles after the hpos sample.
- hires=1 set at vpos=100 -> unchanged scaling through vpos 239. frame_start pulses once at the next origin, and the following frame uses 2x2 pixels with vram_hpos reaching 127.
- Write pal_idx=4 with 3'b100 -> all display_on pixels outside rows 56..183 show 4. Positions with display_on=0 show 0.
- pal_we with idx 2 and data 7, while pixel=2 is displayed on the same cycle -> old colour 2 for that pixel, 7 from the next pixel onward. A write to idx 6 changes nothing.
- VRAM_LAT=3 -> hsync, vsync and rgb all lag the inputs by exactly 5 cycles, and box edges land at hpos 0/256 after the delay.
- reset pulsed low at vpos=80 in hires -> outputs go 0 asynchronously; after release the block stays in lores until the next origin.
